rx_uart: RTL

Serial receiver that pairs with `tx_uart`. It samples an asynchronous 8N1 line, reassembles bytes LSB first and holds each byte in a one-entry buffer until the consumer reads it. The baud-select encoding on `config_data` is the same one `tx_uart` uses, so the existing bring-up harness can loop `tx_line` straight into `rx_line` and program both ends identically.

---
 rtl/rx_uart.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rx_uart.sv
// rx_uart: 8N1 serial receiver with a one-entry read buffer.
// Handshake: a byte is offered while data_available is high; asserting
// read_enable in such a cycle consumes it on the next rising edge. There is
// no backpressure toward the line: a byte that completes while the buffer is
// full overwrites it and raises the sticky overrun flag.
module rx_uart #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic [7:0] config_data,
  input  logic       config_enable,
  input  logic       read_enable,
  output logic [7:0] read_data,
  output logic       data_available,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Cycles per bit for a baud code. Only the low 16 bits are kept, so very
  // slow rates at high clock frequencies wrap.
  function automatic logic [15:0] div_for_code(input logic [3:0] code);
    logic [31:0] baud;
    logic [31:0] quot;
    case (code)
      4'd0:    baud = 32'd300;
      4'd1:    baud = 32'd600;
      4'd2:    baud = 32'd1200;
      4'd3:    baud = 32'd2400;
      4'd4:    baud = 32'd4800;
      4'd5:    baud = 32'd9600;
      4'd6:    baud = 32'd14400;
      4'd7:    baud = 32'd19200;
      4'd8:    baud = 32'd28800;
      4'd9:    baud = 32'd38400;
      4'd10:   baud = 32'd57600;
      4'd11:   baud = 32'd115200;
      default: baud = 32'd9600;
    endcase
    quot = CLK_FREQ / baud;
    return quot[15:0];
  endfunction

  localparam logic [15:0] DIV_RESET = div_for_code(4'd5);

  state_t      state_q, state_d;
  logic        sync1_q;
  logic        rxs_q;
  logic [15:0] div_q, div_d;
  logic [15:0] div_l_q, div_l_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  read_data_q, read_data_d;
  logic        da_q, da_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;

  logic [15:0] half;
  logic        half_done;
  logic        bit_done;
  logic        cfg_hi_unused;

  // Upper nibble of the baud select carries no meaning.
  assign cfg_hi_unused = ^config_data[7:4];

  // HALF always follows the divisor latched for the current frame.
  assign half      = div_l_q >> 1;
  assign half_done = ({1'b0, cnt_q} + 17'd1) >= {1'b0, half};
  assign bit_done  = ({1'b0, cnt_q} + 17'd1) >= {1'b0, div_l_q};

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_line;
      rxs_q   <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      div_q       <= DIV_RESET;
      div_l_q     <= DIV_RESET;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      read_data_q <= '0;
      da_q        <= 1'b0;
      fe_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      div_l_q     <= div_l_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      read_data_q <= read_data_d;
      da_q        <= da_d;
      fe_q        <= fe_d;
      ov_q        <= ov_d;
    end
  end

  // Next-state logic: configuration, buffer consumption, then the frame FSM.
  // Byte completion is evaluated last so it wins over a same-cycle read.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    div_l_d     = div_l_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    read_data_d = read_data_q;
    da_d        = da_q;
    fe_d        = fe_q;
    ov_d        = ov_q;

    if (config_enable) begin
      ov_d = 1'b0;
      if (config_data[3:0] <= 4'd11) begin
        div_d = div_for_code(config_data[3:0]);
      end
    end

    if (read_enable && da_q) begin
      da_d = 1'b0;
      fe_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          div_l_d   = div_q;
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d       = '0;
          read_data_d = shift_q;
          da_d        = 1'b1;
          fe_d        = !rxs_q;
          if (da_q && !read_enable) begin
            ov_d = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign read_data      = read_data_q;
  assign data_available = da_q;
  assign framing_error  = fe_q;
  assign overrun        = ov_q;
  assign busy           = (state_q != S_IDLE);

endmodule
